// File: rtl/softplus_frame_sched.sv
// softplus_frame_sched
//   Buffers one 3x3 frame of signed Q8.8 activations from an upstream
//   valid/ready stream. It then drives a shared, purely combinational
//   softplus unit with one buffered element per cycle and writes each
//   result back into the same buffer slot. Finally it streams the results
//   downstream, marking the last element of the frame. Input is accepted
//   only while loading, so frames never overlap.
//
// Ports
//   clock, rst             : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      : upstream handshake (in_ready high only in LOAD)
//   in_data/in_last        : upstream element and end-of-frame marker
//   sp_operand/sp_result   : operand to / same-cycle result from softplus unit
//   sp_active              : sp_operand carries a live element
//   out_valid/out_ready    : downstream handshake
//   out_data/out_last      : result element and end-of-frame marker
//   busy                   : high in COMPUTE or EMIT
//   err_len/err_clr        : sticky frame-length error and its clear
//   frame_cnt              : completed-frame counter (wraps 255->0)
module softplus_frame_sched #(
  parameter int WIDTH = 16,
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] sp_operand,
  input  logic [WIDTH-1:0] sp_result,
  output logic             sp_active,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err_len,
  input  logic             err_clr,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] len, len_nxt;
  logic [WIDTH-1:0] mem [N];
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic             err_set;
  logic             frame_done;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    len_nxt    = len;
    mem_we     = 1'b0;
    mem_wdata  = in_data;
    err_set    = 1'b0;
    frame_done = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    sp_active  = 1'b0;
    sp_operand = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;

    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          idx_nxt   = idx + 1'b1;
          // A frame closes on in_last or on the N-th element. Inside this
          // branch a length error is exactly "in_last disagrees with the
          // buffer being full": early in_last is short, missing in_last is long.
          if (in_last || (idx == LAST_IDX)) begin
            len_nxt   = idx + 1'b1;
            idx_nxt   = '0;
            state_nxt = COMPUTE;
            err_set   = in_last ^ (idx == LAST_IDX);
          end
        end
      end

      COMPUTE: begin
        busy       = 1'b1;
        sp_active  = 1'b1;
        sp_operand = mem[idx];
        mem_we     = 1'b1;
        mem_wdata  = sp_result;
        idx_nxt    = idx + 1'b1;
        if (idx == len - 1'b1) begin
          idx_nxt   = '0;
          state_nxt = EMIT;
        end
      end

      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[idx];
        out_last  = (idx == len - 1'b1);
        if (out_ready) begin
          idx_nxt = idx + 1'b1;
          if (out_last) begin
            idx_nxt    = '0;
            frame_done = 1'b1;
            state_nxt  = LOAD;
          end
        end
      end

      default: begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      len       <= '0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      len   <= len_nxt;
      if (err_set) begin
        err_len <= 1'b1;
      end else if (err_clr) begin
        err_len <= 1'b0;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Frame buffer carries no reset; its contents are only read after being
  // written by the current frame.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_softplus_frame_sched.sv
module tb_softplus_frame_sched;

  localparam int WIDTH = 16;
  localparam int N     = 9;

  logic             clock;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [WIDTH-1:0] sp_operand;
  logic [WIDTH-1:0] sp_result;
  logic             sp_active;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             err_len;
  logic             err_clr;
  logic [7:0]       frame_cnt;

  softplus_frame_sched #(.WIDTH(WIDTH), .N(N), .IDX_W(4)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sp_operand (sp_operand),
    .sp_result  (sp_result),
    .sp_active  (sp_active),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err_len    (err_len),
    .err_clr    (err_clr),
    .frame_cnt  (frame_cnt)
  );

  // Stub softplus unit
  assign sp_result = sp_operand + 16'h0100;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and model state (updated at negedge, ahead of the posedge
  // where the DUT acts on the same handshake)
  logic [16:0] sb_q[$];
  int          cyc        = 0;
  int          acc_cyc    = 0;
  int          exp_len    = 0;
  int          mon_idx    = 0;
  int          act_cnt    = 0;
  int          exp_frames = 0;
  logic        exp_err    = 1'b0;
  logic        stall      = 1'b0;
  logic        after_last = 1'b0;
  logic        prev_ov    = 1'b0;
  logic [15:0] held_data;
  logic        held_last;

  always @(negedge clock) begin
    logic [16:0] e;
    logic        close;
    logic        set_now;
    cyc++;
    if (rst) begin
      sb_q.delete();
      mon_idx    = 0;
      act_cnt    = 0;
      exp_frames = 0;
      exp_err    = 1'b0;
      stall      = 1'b0;
      after_last = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      set_now = 1'b0;
      if (sp_active) act_cnt++;
      else check("sp_operand_idle", sp_operand, 0);
      if (after_last) begin
        check("in_ready_after_last", in_ready, 1);
        after_last = 1'b0;
      end
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_data);
        check("stall_last", out_last, held_last);
      end
      if (out_valid && !prev_ov) begin
        check("first_valid_latency", cyc - acc_cyc, exp_len + 1);
        check("compute_cycles", act_cnt, exp_len);
        act_cnt = 0;
      end
      if (out_valid) begin
        check("in_ready_while_emit", in_ready, 0);
        if (out_ready) begin
          stall = 1'b0;
          if (sb_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e[15:0]);
            check("out_last", out_last, e[16]);
          end
          if (out_last) begin
            exp_frames = (exp_frames + 1) % 256;
            after_last = 1'b1;
          end
        end else begin
          stall     = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end else begin
        stall = 1'b0;
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        close = in_last || (mon_idx == N - 1);
        sb_q.push_back({close, in_data + 16'h0100});
        acc_cyc = cyc;
        if (close) begin
          exp_len = mon_idx + 1;
          if (in_last != (mon_idx == N - 1)) set_now = 1'b1;
          mon_idx = 0;
        end else begin
          mon_idx++;
        end
      end
      if (set_now) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
    end
  end

  // Downstream ready driver: steady 1, or the 1,0,0,1 stall pattern
  logic       bp_mode = 1'b0;
  logic [3:0] pat     = 4'b1001;
  int         ph      = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bp_mode) begin
        out_ready = pat[ph % 4];
        ph++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic send_elem(input logic [15:0] d, input logic l);
    int tries = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && tries < 500) begin
      tries++;
      @(negedge clock);
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int tries = 0;
    while (tries < 300) begin
      @(posedge clock);
      #1;
      if (sb_q.size() == 0 && in_ready && !out_valid) break;
      tries++;
    end
    if (tries >= 300) check("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    err_clr  = 1'b0;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sp_active", sp_active, 0);
    check("rst_sp_operand", sp_operand, 0);
    check("rst_err_len", err_len, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Nominal frame
    for (int i = 0; i < N; i++) send_elem(16'(i), i == N - 1);
    wait_idle();
    check("nom_frame_cnt", frame_cnt, 1);
    check("nom_err_len", err_len, 0);

    // Backpressure
    do_reset();
    bp_mode = 1'b1;
    for (int i = 0; i < N; i++) send_elem(16'(i), i == N - 1);
    wait_idle();
    bp_mode = 1'b0;
    check("bp_frame_cnt", frame_cnt, 1);

    // Short frame
    do_reset();
    send_elem(16'hFF00, 1'b0);
    send_elem(16'h8000, 1'b0);
    send_elem(16'h7FFF, 1'b1);
    wait_idle();
    check("short_err_len", err_len, 1);
    check("short_err_model", err_len, exp_err);
    err_clr = 1'b1;
    @(posedge clock);
    #1;
    err_clr = 1'b0;
    check("err_clr", err_len, 0);

    // Long frame
    do_reset();
    for (int i = 0; i < 10; i++) send_elem(16'h0010 + 16'(i), i == 9);
    wait_idle();
    check("long_frame_cnt", frame_cnt, 2);
    check("long_err_len", err_len, 1);

    // Reset during COMPUTE at idx=4
    do_reset();
    for (int i = 0; i < N; i++) send_elem(16'h0040 + 16'(i), i == N - 1);
    wait_idle();
    check("pre_rst_frame_cnt", frame_cnt, 1);
    for (int i = 0; i < N; i++) send_elem(16'h0050 + 16'(i), i == N - 1);
    repeat (4) @(posedge clock);
    #1;
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < N; i++) send_elem(16'h0200 + 16'(i), i == N - 1);
    wait_idle();
    check("post_rst_frame_cnt", frame_cnt, 1);

    // frame_cnt wrap with single-element frames
    do_reset();
    for (int i = 0; i < 255; i++) send_elem(16'(i * 3), 1'b1);
    wait_idle();
    check("wrap_frame_cnt_255", frame_cnt, 255);
    send_elem(16'h1234, 1'b1);
    wait_idle();
    check("wrap_frame_cnt_0", frame_cnt, 0);
    check("wrap_model_cnt", frame_cnt, 8'(exp_frames));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/softplus_frame_sched.md
Name: softplus_frame_sched

Overview:
- Sequences one shared combinational softplus unit over 3x3 activation frames: 9 x 16-bit Q8.8 values per frame.
- Buffers one frame from an upstream valid/ready stream.
- Time-multiplexes the external softplus instance one element per cycle, writing each result back in place.
- Streams the results downstream with a last marker.
- Sits between the encoder layer output and the VAE sampling stage.

Parameters:
- WIDTH, 16, data width in signed Q8.8.
- N, 9, elements per frame (3x3).
- IDX_W, 4, index counter width; must satisfy 2^IDX_W > N.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  high only in LOAD.
- in_data  input  WIDTH  upstream element.
- in_last  input  1  upstream end-of-frame marker.
- sp_operand  output  WIDTH  operand to the shared softplus unit.
- sp_result  input  WIDTH  combinational softplus(sp_operand), same cycle.
- sp_active  output  1  high while sp_operand carries a live element.
- out_valid  output  1  result element valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  result element.
- out_last  output  1  high with the final element of a frame.
- busy  output  1  high in COMPUTE or EMIT.
- err_len  output  1  sticky: frame length differed from N.
- err_clr  input  1  clears err_len.
- frame_cnt  output  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - State goes to LOAD; idx=0, len=0.
  - in_ready=1 is reachable the first cycle after reset.
  - Outputs are 0: out_valid, out_last, sp_active, busy, err_len, frame_cnt; sp_operand=0.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial or computed frame with no output.
- State LOAD:
  - in_ready=1.
  - Each in_valid&in_ready cycle writes buf[idx]=in_data and increments idx.
  - The frame closes on an accepted element when in_last=1 or idx==N-1. At close, len=idx+1, idx<=0, next state COMPUTE.
  - If in_last=1 with idx<N-1: short frame; set err_len.
  - If idx==N-1 with in_last=0: long frame; set err_len. Close at N; the following upstream element starts a new frame.
- State COMPUTE:
  - in_ready=0, busy=1, sp_active=1.
  - sp_operand=buf[idx]. Each cycle buf[idx]<=sp_result and idx increments.
  - Runs exactly len cycles. After the cycle with idx==len-1: idx<=0, next state EMIT.
  - sp_operand=0 and sp_active=0 in all other states.
- State EMIT:
  - out_valid=1, out_data=buf[idx], out_last=(idx==len-1).
  - On out_valid&out_ready, idx increments.
  - The handshake on out_last increments frame_cnt, sets idx<=0, next state LOAD.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Timing (full frame, no stalls):
  - 9 accept cycles, then 9 compute cycles.
  - out_valid first rises the cycle after the last compute cycle.
  - Earliest in_ready re-assertion is the cycle after the out_last handshake.
- No overlap: upstream is backpressured for the whole of COMPUTE and EMIT.
- err_len:
  - Set and clear in the same cycle: set wins.
  - err_clr does not otherwise affect the state machine.
- Width rules:
  - Buffer is N x WIDTH registers, no arithmetic applied.
  - sp_result is captured unmodified, so saturation is the softplus unit's concern.
  - idx and len are IDX_W bits; len is in the range 1..N.

Test Plan:
- Nominal frame:
  - Stub sp_result = sp_operand + 16'h0100.
  - Send 16'h0000..16'h0008 with in_last on the 9th element.
  - Required: out_data 16'h0100..16'h0108 in order; out_last only on 16'h0108; frame_cnt=1; err_len=0; first out_valid exactly 10 cycles after the last accept.
- Backpressure:
  - Same frame; toggle out_ready 1,0,0,1 repeatedly.
  - Required: out_data stable while stalled; no drops or duplicates; in_ready=0 until the cycle after the out_last handshake.
- Short frame:
  - Send 3 elements 16'hFF00, 16'h8000, 16'h7FFF with in_last on the 3rd.
  - Required: exactly 3 COMPUTE cycles (sp_active high 3 cycles); 3 outputs 16'h0000, 16'h8100, 16'h80FF; out_last on the 3rd; err_len=1.
  - Then pulse err_clr. Required: err_len=0.
- Long frame:
  - Send 10 elements with in_last only on the 10th.
  - Required: first frame emits 9 results with err_len=1.
  - The 10th element forms a 1-element frame whose output has out_last=1; frame_cnt=2.
- Reset mid-operation:
  - Assert rst for one cycle during COMPUTE (idx=4).
  - Required: the next cycle shows in_ready=1, out_valid=0, busy=0, frame_cnt unchanged-to-0, and no stale output.
  - A following nominal frame produces correct results.
- frame_cnt wrap:
  - Run 256 back-to-back 1-element frames.
  - Required: frame_cnt returns to 0; sp_operand=0 whenever sp_active=0.
